// File: rtl/pwm_capture.sv
// pwm_capture: recovers the 4-bit duty code and the period (in clk cycles) of a PWM input.
// Optional glitch filter on the synchronised input: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [3:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
    logic s, rise;

`ifdef PWM_CAPTURE_DEGLITCH_EN
    logic prev_q, prev_d, filt_q, filt_d;

    // The filtered level only follows two agreeing synchroniser samples, so 1-cycle pulses vanish.
    always_comb begin
        prev_d = sync2_q;
        filt_d = (sync2_q == prev_q) ? sync2_q : filt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            filt_q <= filt_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        s_prev_d = s;
    end

    assign rise = s & ~s_prev_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, idle_cnt_q, idle_cnt_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W:0]   rem_q, rem_d, rem_sh;
    logic [CNT_W-1:0] div_per_q, div_per_d;
    logic [3:0]       quo_q, quo_d, duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d, stuck_q, stuck_d;
    logic             rem_ge, cancel;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        idle_cnt_d = idle_cnt_q;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        div_per_d  = div_per_q;
        quo_d      = quo_q;
        duty_d     = duty_q;
        period_d   = period_q;
        stuck_d    = stuck_q;
        valid_d    = 1'b0;

        rem_sh = rem_q << 1;
        rem_ge = (rem_sh >= {1'b0, div_per_q});
        // A new rise while the divider still holds a result throws that result away.
        cancel = (state_q == MEASURE) && rise && (div_cnt_q != 3'd0);

        if (div_cnt_q > 3'd1) begin
            rem_d     = rem_ge ? (rem_sh - {1'b0, div_per_q}) : rem_sh;
            quo_d     = {quo_q[2:0], rem_ge};
            div_cnt_d = div_cnt_q - 3'd1;
        end else if ((div_cnt_q == 3'd1) && !cancel) begin
            valid_d   = 1'b1;
            duty_d    = quo_q;
            period_d  = div_per_q;
            stuck_d   = 1'b0;
            div_cnt_d = 3'd0;
        end

        case (state_q)
            IDLE: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                if (rise) begin
                    state_d    = MEASURE;
                    per_cnt_d  = CNT_W'(1);
                    hi_cnt_d   = CNT_W'(1);
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TIMEOUT_V) begin
                    // stuck already set means the static level has been reported once
                    if (!stuck_q) begin
                        valid_d  = 1'b1;
                        period_d = '0;
                        stuck_d  = 1'b1;
                        duty_d   = s ? 4'hF : 4'h0;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                per_cnt_d = per_cnt_q + CNT_W'(1);
                hi_cnt_d  = hi_cnt_q + {{(CNT_W-1){1'b0}}, s};
                if (rise) begin
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                    if (cancel) begin
                        div_cnt_d = 3'd0;
                    end else begin
                        rem_d     = {1'b0, hi_cnt_q};
                        div_per_d = per_cnt_q;
                        quo_d     = '0;
                        div_cnt_d = 3'd5;
                    end
                end else if (per_cnt_q == TIMEOUT_V) begin
                    valid_d   = 1'b1;
                    period_d  = '0;
                    stuck_d   = 1'b1;
                    duty_d    = s ? 4'hF : 4'h0;
                    div_cnt_d = 3'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            s_prev_q   <= 1'b0;
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            idle_cnt_q <= '0;
            div_cnt_q  <= 3'd0;
            rem_q      <= '0;
            div_per_q  <= '0;
            quo_q      <= 4'h0;
            duty_q     <= 4'h0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            s_prev_q   <= s_prev_d;
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            div_per_q  <= div_per_d;
            quo_q      <= quo_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms checked every cycle against a sample-history model,
// plus literal expectations for the key reports.
module tb_pwm_capture;

    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 1000;
    localparam int MAXE    = 20000;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [3:0]       duty;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // xs[k]: pwm_in as seen by sampling edge k; fs[k]: two-sample filtered level
    bit xs[MAXE];
    bit fs[MAXE];

    bit m_meas = 1'b0, m_pend = 1'b0, m_rise;
    int m_last, m_due, m_pper, m_phi, m_h, me;
    int idle_start = 0;
    bit exp_valid = 1'b0, exp_stuck = 1'b0;
    int exp_duty = 0, exp_period = 0;

    int valid_cnt = 0;
    int valid_cyc_q[$];
    int last_duty = 0, last_period = 0, last_stuck = 0;
    int min_period = 1 << 30;
    int rise_cyc[8];

    // Level the measurement logic sees in the cycle that ends at edge k.
    function automatic bit sv(input int k);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        return (k >= 3) ? fs[k-3] : 1'b0;
`else
        return (k >= 2) ? xs[k-2] : 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model step at every edge, then compare 1 time unit later.
    always @(posedge clk) begin
        me = cyc;
        if (rst) begin
            for (int j = me - 4; j <= me; j++)
                if (j >= 0 && j < MAXE) begin
                    xs[j] = 1'b0;
                    fs[j] = 1'b0;
                end
            m_meas = 1'b0; m_pend = 1'b0; idle_start = me + 1;
            exp_valid = 1'b0; exp_duty = 0; exp_period = 0; exp_stuck = 1'b0;
        end else if (me < MAXE) begin
            xs[me] = pwm_in;
            fs[me] = (me >= 1 && xs[me] == xs[me-1]) ? xs[me] : ((me >= 1) ? fs[me-1] : 1'b0);
            exp_valid = 1'b0;
            m_rise = sv(me) && !sv(me - 1);
            if (m_meas) begin
                if (m_rise) begin
                    if (m_pend && m_due >= me) begin
                        m_pend = 1'b0;
                    end else begin
                        m_h = 0;
                        for (int j = m_last; j < me; j++) m_h += int'(sv(j));
                        m_pend = 1'b1; m_due = me + 5; m_pper = me - m_last; m_phi = m_h;
                    end
                    m_last = me;
                end else if (me - m_last == TIMEOUT) begin
                    exp_valid = 1'b1; exp_period = 0; exp_stuck = 1'b1;
                    exp_duty = sv(me) ? 15 : 0;
                    m_meas = 1'b0; m_pend = 1'b0;
                end
            end else if (m_rise) begin
                m_meas = 1'b1; m_last = me;
            end else if (me - idle_start == TIMEOUT && !exp_stuck) begin
                exp_valid = 1'b1; exp_period = 0; exp_stuck = 1'b1;
                exp_duty = sv(me) ? 15 : 0;
            end
            if (m_pend && m_due == me) begin
                exp_valid = 1'b1; exp_duty = (m_phi * 16) / m_pper;
                exp_period = m_pper; exp_stuck = 1'b0; m_pend = 1'b0;
            end
        end
        cyc = me + 1;
        #1;
        checkOutput("valid", int'(valid), int'(exp_valid));
        checkOutput("duty", int'(duty), exp_duty);
        checkOutput("period", int'(period), exp_period);
        checkOutput("stuck", int'(stuck), int'(exp_stuck));
        if (valid) begin
            valid_cnt++;
            valid_cyc_q.push_back(me);
            last_duty = int'(duty);
            last_period = int'(period);
            last_stuck = int'(stuck);
            if (int'(period) < min_period) min_period = int'(period);
        end
    end

    // n periods of the given length and high time; glitch > 0 adds a 1-cycle pulse at that offset.
    task automatic applyStimulus(input int per, input int hi, input int n, input int glitch);
        for (int k = 0; k < n; k++) begin
            pwm_in = 1'b1;
            if (k < 8) rise_cyc[k] = cyc;
            repeat (hi) @(negedge clk);
            for (int j = hi; j < per; j++) begin
                pwm_in = (glitch != 0 && j == glitch);
                @(negedge clk);
            end
        end
        pwm_in = 1'b0;
    endtask

    task automatic waitValid(input int maxc, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (valid_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit ok;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("reset_duty", int'(duty), 0);
        checkOutput("reset_period", int'(period), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_stuck", int'(stuck), 0);

        $display("[TB] idle input from reset");
        base = valid_cnt;
        waitValid(1200, base, ok);
        checkOutput("idle_timeout_seen", int'(ok), 1);
        if (ok) begin
            checkOutput("idle_timeout_cycle", valid_cyc_q[base], 3 + TIMEOUT);
            checkOutput("idle_stuck", last_stuck, 1);
            checkOutput("idle_duty", last_duty, 0);
            checkOutput("idle_period", last_period, 0);
        end
        repeat (1200) @(negedge clk);
        checkOutput("idle_single_report", valid_cnt - base, 1);

        $display("[TB] 160/60 waveform");
        base = valid_cnt;
        applyStimulus(160, 60, 3, 0);
        checkOutput("t1_reports", valid_cnt - base, 2);
        if (valid_cnt - base >= 1)
            checkOutput("t1_latency", valid_cyc_q[base] - rise_cyc[1], LAT);
        checkOutput("t1_duty", last_duty, 6);
        checkOutput("t1_period", last_period, 160);
        checkOutput("t1_stuck", last_stuck, 0);

        $display("[TB] 160/150 and 160/10 waveforms");
        applyStimulus(160, 150, 3, 0);
        checkOutput("t2_duty_hi", last_duty, 15);
        checkOutput("t2_interval_hi", valid_cyc_q[valid_cnt-1] - valid_cyc_q[valid_cnt-2], 160);
        applyStimulus(160, 10, 3, 0);
        checkOutput("t2_duty_lo", last_duty, 1);
        checkOutput("t2_interval_lo", valid_cyc_q[valid_cnt-1] - valid_cyc_q[valid_cnt-2], 160);

        $display("[TB] input stuck high");
        applyStimulus(160, 60, 2, 0);
        pwm_in = 1'b1;
        base = valid_cnt;
        repeat (1200) @(negedge clk);
        checkOutput("t4_reports", valid_cnt - base, 2);
        checkOutput("t4_stuck", last_stuck, 1);
        checkOutput("t4_duty", last_duty, 15);
        checkOutput("t4_period", last_period, 0);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        applyStimulus(160, 60, 3, 0);
        checkOutput("t4_restart_stuck", last_stuck, 0);
        checkOutput("t4_restart_duty", last_duty, 6);

        $display("[TB] reset during division");
        base = valid_cnt;
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        pwm_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("t5_duty", int'(duty), 0);
        checkOutput("t5_period", int'(period), 0);
        checkOutput("t5_stuck", int'(stuck), 0);
        repeat (150) @(negedge clk);
        checkOutput("t5_no_report", valid_cnt - base, 0);
        base = valid_cnt;
        applyStimulus(160, 60, 2, 0);
        checkOutput("t5_reports", valid_cnt - base, 1);
        if (valid_cnt - base >= 1)
            checkOutput("t5_latency", valid_cyc_q[base] - rise_cyc[1], LAT);

        $display("[TB] glitch in low phase");
        base = valid_cnt;
        min_period = 1 << 30;
        applyStimulus(160, 60, 4, 110);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        checkOutput("t6_reports", valid_cnt - base, 4);
        checkOutput("t6_min_period", min_period, 160);
        checkOutput("t6_duty", last_duty, 6);
`else
        checkOutput("t6_reports", valid_cnt - base, 8);
        checkOutput("t6_min_period", min_period, 50);
        checkOutput("t6_duty", last_duty, 8);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
